// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Holds the FSM encoding, line geometry and word-index width.
package mem_arb_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 3;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FILL_I,
        FILL_D,
        DONE
    } state_t;

endpackage

// File: rtl/word_ctr.sv
// Word index counter: synchronous clear has priority over enable.
// Ports: clk, rst (async high), clr, en, cnt (wraps at the top).
module word_ctr
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [WORD_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WORD_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-fill, D-fill and D write-through onto one memory port.
// Ports: request/address inputs per client, memory port, fill strobes.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        I_miss,
    input  logic [15:0] I_miss_addr,
    input  logic        D_miss,
    input  logic [15:0] D_miss_addr,
    input  logic        D_wr_req,
    input  logic [15:0] D_wr_addr,
    input  logic [15:0] D_wr_data,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_out,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        I_fill_we,
    output logic        D_fill_we,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        I_fill_done,
    output logic        D_fill_done,
    output logic        D_wr_ack,
    output logic        busy
);

    state_t            state_q, state_d;
    logic [15:0]       addr_q;
    logic [15:0]       data_q;
    logic              own_d_q;
    logic              issue_done_q;
    logic              ctr_clr;
    logic              issue_en;
    logic              recv_en;
    logic [WORD_W-1:0] issue_cnt;
    logic [WORD_W-1:0] recv_cnt;

    word_ctr u_issue (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (issue_en),
        .cnt (issue_cnt)
    );

    word_ctr u_recv (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (recv_en),
        .cnt (recv_cnt)
    );

    always_comb begin
        state_d     = state_q;
        ctr_clr     = 1'b0;
        issue_en    = 1'b0;
        recv_en     = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        I_fill_we   = 1'b0;
        D_fill_we   = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        I_fill_done = 1'b0;
        D_fill_done = 1'b0;
        D_wr_ack    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (D_wr_req) begin
                    state_d = WRITE;
                end else if (D_miss) begin
                    state_d = FILL_D;
                    ctr_clr = 1'b1;
                end else if (I_miss) begin
                    state_d = FILL_I;
                    ctr_clr = 1'b1;
                end
            end
            WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_q;
                mem_data_in = data_q;
                D_wr_ack    = 1'b1;
                state_d     = IDLE;
            end
            FILL_I, FILL_D: begin
                // Issue and receive sides run independently so any
                // memory latency works.
                if (!issue_done_q) begin
                    mem_en   = 1'b1;
                    mem_addr = {addr_q[15:4], issue_cnt, 1'b0};
                    issue_en = 1'b1;
                end
                if (mem_data_valid) begin
                    fill_word = recv_cnt;
                    fill_data = mem_data_out;
                    I_fill_we = (state_q == FILL_I);
                    D_fill_we = (state_q == FILL_D);
                    recv_en   = 1'b1;
                    if (recv_cnt == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                I_fill_done = !own_d_q;
                D_fill_done = own_d_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            own_d_q      <= 1'b0;
            issue_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (D_wr_req) begin
                    addr_q <= D_wr_addr;
                    data_q <= D_wr_data;
                end else if (D_miss) begin
                    addr_q  <= D_miss_addr;
                    own_d_q <= 1'b1;
                end else if (I_miss) begin
                    addr_q  <= I_miss_addr;
                    own_d_q <= 1'b0;
                end
            end
            // The issue counter wraps after the last word, so a flag
            // remembers that the whole line has been requested.
            if (ctr_clr) begin
                issue_done_q <= 1'b0;
            end else if (issue_en && issue_cnt == LAST_WORD) begin
                issue_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory.
// Scenario tasks log activity per cycle and check it inline.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_miss = 1'b0;
    logic [15:0] I_miss_addr = '0;
    logic        D_miss = 1'b0;
    logic [15:0] D_miss_addr = '0;
    logic        D_wr_req = 1'b0;
    logic [15:0] D_wr_addr = '0;
    logic [15:0] D_wr_data = '0;
    logic        mem_data_valid;
    logic [15:0] mem_data_out;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        I_fill_we, D_fill_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        I_fill_done, D_fill_done, D_wr_ack, busy;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .I_miss         (I_miss),
        .I_miss_addr    (I_miss_addr),
        .D_miss         (D_miss),
        .D_miss_addr    (D_miss_addr),
        .D_wr_req       (D_wr_req),
        .D_wr_addr      (D_wr_addr),
        .D_wr_data      (D_wr_data),
        .mem_data_valid (mem_data_valid),
        .mem_data_out   (mem_data_out),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .I_fill_we      (I_fill_we),
        .D_fill_we      (D_fill_we),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .I_fill_done    (I_fill_done),
        .D_fill_done    (D_fill_done),
        .D_wr_ack       (D_wr_ack),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Memory model: read data = addr ^ A5A5, four cycles after issue.
    logic [3:0]  pv = '0;
    logic [15:0] pa [4];
    logic        stray = 1'b0;
    logic [15:0] stray_d = '0;

    always_ff @(posedge clk) begin
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end

    assign mem_data_valid = pv[3] | stray;
    assign mem_data_out   = pv[3] ? (pa[3] ^ 16'hA5A5) : stray_d;

    wire [58:0] all_out = {mem_en, mem_wr, mem_addr, mem_data_in,
                           I_fill_we, D_fill_we, fill_word, fill_data,
                           I_fill_done, D_fill_done, D_wr_ack, busy};

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    int          n_rd, n_wr, n_f, n_ifd, n_dfd, n_ack, n_both;
    logic [15:0] rd_a [32];
    int          rd_c [32];
    logic [15:0] wr_a, wr_d;
    int          wr_c, ack_c, ifd_c, dfd_c;
    logic        f_d [32];
    logic [2:0]  f_w [32];
    logic [15:0] f_v [32];

    task automatic clear_logs();
        n_rd = 0; n_wr = 0; n_f = 0; n_ifd = 0; n_dfd = 0;
        n_ack = 0; n_both = 0;
        wr_a = '0; wr_d = '0; wr_c = -1; ack_c = -1;
        ifd_c = -1; dfd_c = -1;
    endtask

    // One cycle: sample at negedge, log, and drop finished requests.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_en && !mem_wr && n_rd < 32) begin
            rd_a[n_rd] = mem_addr;
            rd_c[n_rd] = cyc;
            n_rd++;
        end
        if (mem_en && mem_wr) begin
            wr_a = mem_addr;
            wr_d = mem_data_in;
            wr_c = cyc;
            n_wr++;
        end
        if (I_fill_we && D_fill_we) n_both++;
        if ((I_fill_we || D_fill_we) && n_f < 32) begin
            f_d[n_f] = D_fill_we;
            f_w[n_f] = fill_word;
            f_v[n_f] = fill_data;
            n_f++;
        end
        if (I_fill_done) begin
            n_ifd++; ifd_c = cyc; I_miss = 1'b0;
        end
        if (D_fill_done) begin
            n_dfd++; dfd_c = cyc; D_miss = 1'b0;
        end
        if (D_wr_ack) begin
            n_ack++; ack_c = cyc; D_wr_req = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((busy || I_miss || D_miss || D_wr_req) && k < max_cyc);
        checks++;
        if (busy || I_miss || D_miss || D_wr_req) begin
            errs++;
            $display("FAIL wait_idle: busy=%0b still pending after %0d cycles",
                     busy, k);
        end
    endtask

    task automatic test_reset();
        I_miss = 1'b1;
        I_miss_addr = 16'h0124;
        step();
        checks++;
        if (all_out !== 59'd0) begin
            errs++;
            $display("FAIL reset_outs: got %h want 0", all_out);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        I_miss = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (all_out !== 59'd0) begin
            errs++;
            $display("FAIL idle_outs: got %h want 0", all_out);
        end
    endtask

    task automatic test_stray();
        stray = 1'b1;
        stray_d = 16'h7777;
        #1;
        checks++;
        if ({I_fill_we, D_fill_we, fill_data} !== 18'd0) begin
            errs++;
            $display("FAIL stray_we: got %b/%b/%h want 0/0/0000",
                     I_fill_we, D_fill_we, fill_data);
        end
        step();
        stray = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL stray_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_i_fill();
        int t0;
        logic [15:0] ea;
        clear_logs();
        I_miss_addr = 16'h0124;
        I_miss = 1'b1;
        t0 = cyc;
        wait_idle(60);
        checks++;
        if (n_rd !== 8) begin
            errs++;
            $display("FAIL ifill_nrd: got %0d want 8", n_rd);
        end
        for (int k = 0; k < 8; k++) begin
            ea = 16'h0120 + 16'(2 * k);
            checks++;
            if (rd_a[k] !== ea || rd_c[k] !== t0 + 1 + k) begin
                errs++;
                $display("FAIL ifill_rd%0d: got %h@%0d want %h@%0d",
                         k, rd_a[k], rd_c[k], ea, t0 + 1 + k);
            end
        end
        checks++;
        if (n_f !== 8) begin
            errs++;
            $display("FAIL ifill_nf: got %0d want 8", n_f);
        end
        for (int k = 0; k < 8; k++) begin
            ea = 16'h0120 + 16'(2 * k);
            checks++;
            if (f_d[k] !== 1'b0 || f_w[k] !== 3'(k) ||
                f_v[k] !== (ea ^ 16'hA5A5)) begin
                errs++;
                $display("FAIL ifill_w%0d: got d=%b w=%0d v=%h want 0 %0d %h",
                         k, f_d[k], f_w[k], f_v[k], k, ea ^ 16'hA5A5);
            end
        end
        checks++;
        if (n_ifd !== 1 || n_dfd !== 0 || n_both !== 0) begin
            errs++;
            $display("FAIL ifill_done: got ifd=%0d dfd=%0d both=%0d want 1 0 0",
                     n_ifd, n_dfd, n_both);
        end
    endtask

    task automatic test_dual();
        logic [15:0] ea;
        clear_logs();
        I_miss_addr = 16'h0240;
        D_miss_addr = 16'h8008;
        I_miss = 1'b1;
        D_miss = 1'b1;
        wait_idle(80);
        checks++;
        if (n_rd !== 16 || n_f !== 16) begin
            errs++;
            $display("FAIL dual_n: got rd=%0d f=%0d want 16 16", n_rd, n_f);
        end
        for (int k = 0; k < 16; k++) begin
            ea = (k < 8) ? 16'h8000 + 16'(2 * k)
                         : 16'h0240 + 16'(2 * (k - 8));
            checks++;
            if (rd_a[k] !== ea || f_d[k] !== (k < 8) || f_w[k] !== 3'(k % 8)) begin
                errs++;
                $display("FAIL dual_%0d: got a=%h d=%b w=%0d want %h %b %0d",
                         k, rd_a[k], f_d[k], f_w[k], ea, k < 8, k % 8);
            end
        end
        checks++;
        if (n_dfd !== 1 || n_ifd !== 1 || ifd_c <= dfd_c) begin
            errs++;
            $display("FAIL dual_done: got dfd=%0d@%0d ifd=%0d@%0d want 1 then 1",
                     n_dfd, dfd_c, n_ifd, ifd_c);
        end
        checks++;
        if (rd_c[8] - dfd_c > 2 || rd_c[8] <= dfd_c) begin
            errs++;
            $display("FAIL dual_gap: got I start %0d after D done %0d want <=2",
                     rd_c[8], dfd_c);
        end
    endtask

    task automatic test_write();
        int t0;
        clear_logs();
        D_wr_addr = 16'h4002;
        D_wr_data = 16'hBEEF;
        D_wr_req = 1'b1;
        D_miss_addr = 16'h3056;
        D_miss = 1'b1;
        t0 = cyc;
        wait_idle(60);
        checks++;
        if (n_wr !== 1 || wr_a !== 16'h4002 || wr_d !== 16'hBEEF) begin
            errs++;
            $display("FAIL wr_beat: got n=%0d %h/%h want 1 4002/BEEF",
                     n_wr, wr_a, wr_d);
        end
        checks++;
        if (wr_c !== t0 + 1 || n_ack !== 1 || ack_c !== wr_c) begin
            errs++;
            $display("FAIL wr_ack: got wr@%0d ack=%0d@%0d want wr@%0d ack=1 same",
                     wr_c, n_ack, ack_c, t0 + 1);
        end
        checks++;
        if (n_rd !== 8 || rd_a[0] !== 16'h3050 || rd_c[0] !== wr_c + 2) begin
            errs++;
            $display("FAIL wr_dfill: got n=%0d %h@%0d want 8 3050@%0d",
                     n_rd, rd_a[0], rd_c[0], wr_c + 2);
        end
        checks++;
        if (n_f !== 8 || n_dfd !== 1 || f_d[7] !== 1'b1 || f_w[7] !== 3'd7) begin
            errs++;
            $display("FAIL wr_dfill_done: got f=%0d dfd=%0d want 8 1",
                     n_f, n_dfd);
        end
    endtask

    task automatic test_wr_during_fill();
        clear_logs();
        I_miss_addr = 16'h1000;
        I_miss = 1'b1;
        repeat (3) step();
        D_wr_addr = 16'h2222;
        D_wr_data = 16'h1234;
        D_wr_req = 1'b1;
        wait_idle(80);
        checks++;
        if (n_wr !== 1 || wr_a !== 16'h2222 || wr_d !== 16'h1234) begin
            errs++;
            $display("FAIL wdf_beat: got n=%0d %h/%h want 1 2222/1234",
                     n_wr, wr_a, wr_d);
        end
        checks++;
        if (n_ifd !== 1 || wr_c <= ifd_c || n_ack !== 1 || ack_c !== wr_c) begin
            errs++;
            $display("FAIL wdf_order: got ifd=%0d@%0d wr@%0d ack=%0d want wr after",
                     n_ifd, ifd_c, wr_c, n_ack);
        end
        checks++;
        if (n_rd !== 8 || n_f !== 8) begin
            errs++;
            $display("FAIL wdf_fill: got rd=%0d f=%0d want 8 8", n_rd, n_f);
        end
    endtask

    task automatic test_rst_mid();
        int k;
        clear_logs();
        I_miss_addr = 16'h5000;
        I_miss = 1'b1;
        k = 0;
        while (n_f < 3 && k < 30) begin
            step();
            k++;
        end
        checks++;
        if (n_f !== 3) begin
            errs++;
            $display("FAIL rmid_reach: got %0d words want 3", n_f);
        end
        rst = 1'b1;
        I_miss = 1'b0;
        #1;
        checks++;
        if (all_out !== 59'd0) begin
            errs++;
            $display("FAIL rmid_async: got %h want 0", all_out);
        end
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        checks++;
        if (n_ifd !== 0 || n_f !== 3 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rmid_quiet: got ifd=%0d f=%0d busy=%b want 0 3 0",
                     n_ifd, n_f, busy);
        end
        clear_logs();
        I_miss = 1'b1;
        wait_idle(60);
        checks++;
        if (n_rd !== 8 || rd_a[0] !== 16'h5000 || rd_a[7] !== 16'h500E) begin
            errs++;
            $display("FAIL rmid_rerd: got n=%0d %h..%h want 8 5000..500E",
                     n_rd, rd_a[0], rd_a[7]);
        end
        checks++;
        if (n_f !== 8 || f_w[0] !== 3'd0 || f_w[7] !== 3'd7 ||
            f_v[0] !== (16'h5000 ^ 16'hA5A5) || n_ifd !== 1) begin
            errs++;
            $display("FAIL rmid_refill: got f=%0d w0=%0d v0=%h ifd=%0d want 8 0 %h 1",
                     n_f, f_w[0], f_v[0], n_ifd, 16'h5000 ^ 16'hA5A5);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_stray();
        test_i_fill();
        test_dual();
        test_write();
        test_wr_during_fill();
        test_rst_mid();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
